// File: rtl/trdb_trace_ctrl.sv
// Trace session controller: arbitrates start/stop of tracing, requests START/STOP
// control packets, and drains the encoder FIFO (with timeout) before returning idle.
module trdb_trace_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       trace_enable_i,
    input  logic       trace_qualified_i,
    input  logic       trigger_trace_on_i,
    input  logic       trigger_trace_off_i,
    input  logic       inst_valid_i,
    input  logic       pkt_ack_i,
    input  logic       fifo_empty_i,
    output logic       pkt_req_o,
    output logic [1:0] pkt_type_o,
    output logic       encoder_en_o,
    output logic       trace_req_deactivate_o,
    output logic       drain_timeout_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_REQ = 3'd1,
        ACTIVE    = 3'd2,
        STOP_REQ  = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    localparam logic [1:0] PKT_NONE  = 2'b00;
    localparam logic [1:0] PKT_START = 2'b01;
    localparam logic [1:0] PKT_STOP  = 2'b10;
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [7:0] drain_cnt;
    logic       stop_by_trigger;
    logic       start_cond;
    logic       stop_cond;

    // A trigger-off request always dominates a simultaneous trigger-on.
    assign start_cond = trace_enable_i & ~trigger_trace_off_i &
                        (trigger_trace_on_i | (trace_qualified_i & inst_valid_i));
    assign stop_cond  = ~trace_enable_i | trigger_trace_off_i | ~trace_qualified_i;

    assign state_o = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                  <= IDLE;
            drain_cnt              <= 8'd0;
            stop_by_trigger        <= 1'b0;
            pkt_req_o              <= 1'b0;
            pkt_type_o             <= PKT_NONE;
            encoder_en_o           <= 1'b0;
            trace_req_deactivate_o <= 1'b0;
            drain_timeout_o        <= 1'b0;
        end else begin
            trace_req_deactivate_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_cond) begin
                        state           <= START_REQ;
                        pkt_req_o       <= 1'b1;
                        pkt_type_o      <= PKT_START;
                        drain_timeout_o <= 1'b0;
                    end
                end
                // Request is held unchanged until acknowledged, whatever the stop condition does.
                START_REQ: begin
                    if (pkt_ack_i) begin
                        state        <= ACTIVE;
                        pkt_req_o    <= 1'b0;
                        pkt_type_o   <= PKT_NONE;
                        encoder_en_o <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (stop_cond) begin
                        state           <= STOP_REQ;
                        encoder_en_o    <= 1'b0;
                        pkt_req_o       <= 1'b1;
                        pkt_type_o      <= PKT_STOP;
                        stop_by_trigger <= trigger_trace_off_i;
                    end
                end
                STOP_REQ: begin
                    if (pkt_ack_i) begin
                        state      <= DRAIN;
                        pkt_req_o  <= 1'b0;
                        pkt_type_o <= PKT_NONE;
                        drain_cnt  <= 8'd0;
                    end
                end
                // Empty FIFO takes priority over the timeout on the same cycle.
                DRAIN: begin
                    if (!fifo_empty_i) begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                    if (fifo_empty_i || drain_cnt == DRAIN_LAST) begin
                        state                  <= IDLE;
                        trace_req_deactivate_o <= stop_by_trigger;
                        stop_by_trigger        <= 1'b0;
                        if (!fifo_empty_i) begin
                            drain_timeout_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    drain_cnt       <= 8'd0;
                    stop_by_trigger <= 1'b0;
                    pkt_req_o       <= 1'b0;
                    pkt_type_o      <= PKT_NONE;
                    encoder_en_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/trdb_trace_ctrl.md
TRDB_TRACE_CTRL -- requirements
Module: trdb_trace_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 16, SHALL set the maximum cycles spent waiting for the output FIFO to empty after a stop packet; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 trace_enable_i  input  1  tracing enabled, from the control register.
REQ-005 trace_qualified_i  input  1  non-compressed qualification from the filter.
REQ-006 trigger_trace_on_i  input  1  trigger-unit start request.
REQ-007 trigger_trace_off_i  input  1  trigger-unit stop request.
REQ-008 inst_valid_i  input  1  retired instruction valid this cycle.
REQ-009 pkt_ack_i  input  1  packet emitter accepted the current request.
REQ-010 fifo_empty_i  input  1  encoder output FIFO empty.
REQ-011 pkt_req_o  output  1  request to emit a control packet.
REQ-012 pkt_type_o  output  2  2'b01 START, 2'b10 STOP, 2'b00 otherwise.
REQ-013 encoder_en_o  output  1  packet generation enabled.
REQ-014 trace_req_deactivate_o  output  1  one-cycle pulse asking software to clear trace_enable.
REQ-015 drain_timeout_o  output  1  sticky flag: drain ended by timeout.
REQ-016 state_o  output  3  current state encoding, for debug.

Function
REQ-017 The FSM SHALL have states IDLE=0, START_REQ=1, ACTIVE=2, STOP_REQ=3, DRAIN=4; other encodings are unreachable and SHALL return to IDLE.
REQ-018 Start condition = trace_enable_i & ~trigger_trace_off_i & (trigger_trace_on_i | (trace_qualified_i & inst_valid_i)).
REQ-019 Stop condition = ~trace_enable_i | trigger_trace_off_i | ~trace_qualified_i.
REQ-020 IDLE -> START_REQ on the next edge when the start condition is true; otherwise stay in IDLE.
REQ-021 START_REQ: pkt_req_o=1 and pkt_type_o=START; both are held until pkt_ack_i=1; on ack go to ACTIVE.
REQ-022 A request SHALL never be retracted or changed before ack, even if the stop condition arises during START_REQ.
REQ-023 ACTIVE: encoder_en_o=1; when the stop condition is true, go to STOP_REQ on the next edge (encoder_en_o=0 from that edge).
REQ-024 ACTIVE entered after a START ack while the stop condition is already true SHALL last exactly one cycle.
REQ-025 STOP_REQ: pkt_req_o=1 and pkt_type_o=STOP, held until pkt_ack_i; on ack go to DRAIN and clear the drain counter to 0.
REQ-026 pkt_ack_i SHALL be ignored when pkt_req_o=0.
REQ-027 DRAIN: the 8-bit counter increments each cycle fifo_empty_i=0.
REQ-028 DRAIN -> IDLE when fifo_empty_i=1.
REQ-029 DRAIN -> IDLE also when the counter equals DRAIN_CYCLES-1 with fifo_empty_i=0; in that case drain_timeout_o is set.
REQ-030 If fifo_empty_i=1 and the counter equals DRAIN_CYCLES-1 in the same cycle, the empty exit wins and drain_timeout_o is not set.
REQ-031 drain_timeout_o SHALL stay set until reset or until the next IDLE->START_REQ transition clears it.
REQ-032 A stop_by_trigger bit SHALL be set when the stop condition is taken in ACTIVE with trigger_trace_off_i=1, and cleared on entering IDLE.
REQ-033 trace_req_deactivate_o SHALL pulse for exactly one cycle, the cycle after DRAIN->IDLE, when stop_by_trigger was set.
REQ-034 If trigger_trace_on_i and trigger_trace_off_i are both 1, off wins: no start from IDLE, and stop from ACTIVE.
REQ-035 The block SHALL spend at least one cycle in IDLE between DRAIN and START_REQ.
REQ-036 pkt_type_o SHALL be 2'b00 whenever pkt_req_o=0.

Reset
REQ-037 While rst_i=1, regardless of clock: state IDLE, all outputs 0, drain counter 0, stop_by_trigger 0, drain_timeout_o 0.
REQ-038 Reset asserted mid-request SHALL drop pkt_req_o immediately, without waiting for ack.
REQ-039 The first state change after rst_i deasserts SHALL occur on the first rising edge with rst_i=0.

Verification
REQ-040 Basic start/stop: enable=1, qualified=1, inst_valid pulse -> START_REQ; ack after 3 cycles -> ACTIVE with encoder_en_o=1; then enable=0 -> STOP packet; ack with fifo_empty=1 -> IDLE; no deactivate pulse.
REQ-041 Trigger off: in ACTIVE, trigger_trace_off_i pulses -> STOP, DRAIN, IDLE; trace_req_deactivate_o high exactly one cycle after IDLE entry.
REQ-042 Drain timeout: DRAIN_CYCLES=4, fifo_empty=0 throughout -> IDLE after 4 DRAIN cycles, drain_timeout_o=1, held until the next start.
REQ-043 Stop during START_REQ: enable drops before ack -> START held until ack, one ACTIVE cycle, then STOP_REQ.
REQ-044 Conflicting triggers: on=off=1 in IDLE -> stays IDLE; on=off=1 in ACTIVE -> STOP_REQ.
REQ-045 Reset in STOP_REQ: assert rst_i between edges -> pkt_req_o=0 and state_o=0 before the next edge.
